// File: rtl/ws2812_in_if.sv
// WS2812 receiver bus: async serial input, latched frame outputs and the
// optional downstream data line. The bench drives through master; the
// decoder sits on slave.
interface ws2812_in_if #(
   parameter int LED_CNT = 7
);
   localparam int PW = $clog2(LED_CNT + 1);

   logic                   din;
   logic [24*LED_CNT-1:0]  data_out;
   logic                   frame_valid;
   logic [PW-1:0]          pix_count;
   logic                   dout;

   modport master (output din, input data_out, frame_valid, pix_count, dout);
   modport slave  (input din, output data_out, frame_valid, pix_count, dout);
endinterface

// File: rtl/ws2812_in.sv
// ws2812_in: WS2812 one-wire stream decoder. Measures synced high-pulse
// widths to recover GRB bits, stages the first LED_CNT pixels, and latches
// them onto data_out when a reset gap of RESET_CYC low cycles is seen.
// Optional feature macro: WS2812_IN_PASSTHRU_EN forwards overflow pixels
// (those beyond LED_CNT) on dout; without it dout is tied low.
module ws2812_in #(
   parameter int LED_CNT    = 7,
   parameter int THRESH_CYC = 6,
   parameter int MIN_CYC    = 2,
   parameter int RESET_CYC  = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   ws2812_in_if.slave bus
);
   localparam int PW = $clog2(LED_CNT + 1);
   localparam int HW = $clog2(THRESH_CYC + 1);
   localparam int LW = $clog2(RESET_CYC + 1);

   typedef enum logic {ST_LOW, ST_HIGH} state_t;

   logic                  s1_q, s_q;
   state_t                state_q, state_d;
   logic [LW-1:0]         low_cnt_q, low_cnt_d;
   logic [HW-1:0]         high_cnt_q, high_cnt_d;
   logic [22:0]           shift_q;
   logic [23:0]           shift_d;
   logic [4:0]            bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]         pix_idx_q, pix_idx_d;
   logic [23:0]           staging_q [LED_CNT];
   logic [23:0]           data_q    [LED_CNT];
   logic                  frame_valid_q;
   logic [PW-1:0]         pix_count_q;
   logic [24*LED_CNT-1:0] data_out_w;
   logic                  pix_wr, latch, low_sat, bit_val;

   // Two-flop synchroniser for the asynchronous data line
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s_q  <= 1'b0;
      end else begin
         s1_q <= bus.din;
         s_q  <= s1_q;
      end
   end

   // Pulse-width decoder: next state, bit shifting, pixel and frame boundaries
   always_comb begin
      state_d    = state_q;
      low_cnt_d  = low_cnt_q;
      high_cnt_d = high_cnt_q;
      shift_d    = {1'b0, shift_q};
      bit_cnt_d  = bit_cnt_q;
      pix_idx_d  = pix_idx_q;
      pix_wr     = 1'b0;
      latch      = 1'b0;
      low_sat    = (low_cnt_q == LW'(RESET_CYC));
      bit_val    = (high_cnt_q >= HW'(THRESH_CYC));
      case (state_q)
         ST_LOW: begin
            if (s_q) begin
               state_d    = ST_HIGH;
               high_cnt_d = HW'(1);
            end else if (!low_sat) begin
               low_cnt_d = low_cnt_q + 1'b1;
               latch     = (low_cnt_q == LW'(RESET_CYC - 1));
            end
         end
         ST_HIGH: begin
            if (s_q) begin
               if (high_cnt_q != HW'(THRESH_CYC))
                  high_cnt_d = high_cnt_q + 1'b1;
            end else if (high_cnt_q < HW'(MIN_CYC)) begin
               // Glitch: no bit, and the low gap it interrupted keeps counting
               state_d = ST_LOW;
               if (!low_sat) begin
                  low_cnt_d = low_cnt_q + 1'b1;
                  latch     = (low_cnt_q == LW'(RESET_CYC - 1));
               end
            end else begin
               state_d   = ST_LOW;
               low_cnt_d = '0;
               shift_d   = {shift_q, bit_val};
               if (bit_cnt_q == 5'd23) begin
                  bit_cnt_d = '0;
                  pix_wr    = (pix_idx_q < PW'(LED_CNT));
                  if (pix_idx_q != PW'(LED_CNT))
                     pix_idx_d = pix_idx_q + 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_LOW;
      endcase
      // A reset gap ends the frame; any partial pixel is dropped
      if (latch) begin
         pix_idx_d = '0;
         bit_cnt_d = '0;
         shift_d   = '0;
      end
   end

   // Decoder state, staging writes and frame latch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_LOW;
         low_cnt_q     <= '0;
         high_cnt_q    <= '0;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         pix_idx_q     <= '0;
         frame_valid_q <= 1'b0;
         pix_count_q   <= '0;
         for (int i = 0; i < LED_CNT; i++) begin
            staging_q[i] <= '0;
            data_q[i]    <= '0;
         end
      end else begin
         state_q       <= state_d;
         low_cnt_q     <= low_cnt_d;
         high_cnt_q    <= high_cnt_d;
         shift_q       <= shift_d[22:0];
         bit_cnt_q     <= bit_cnt_d;
         pix_idx_q     <= pix_idx_d;
         frame_valid_q <= latch && (pix_idx_q != '0);
         if (latch && (pix_idx_q != '0))
            pix_count_q <= pix_idx_q;
         for (int i = 0; i < LED_CNT; i++) begin
            if (pix_wr && (pix_idx_q == PW'(i)))
               staging_q[i] <= shift_d;
            // Only slots filled this frame are refreshed; others keep old data
            if (latch && (pix_idx_q > PW'(i)))
               data_q[i] <= staging_q[i];
         end
      end
   end

   // Pixel 0 occupies the top 24 bits of data_out
   for (genvar gi = 0; gi < LED_CNT; gi++) begin : g_out
      assign data_out_w[24*(LED_CNT-gi)-1 -: 24] = data_q[gi];
   end

   assign bus.data_out    = data_out_w;
   assign bus.frame_valid = frame_valid_q;
   assign bus.pix_count   = pix_count_q;

`ifdef WS2812_IN_PASSTHRU_EN
   logic fwd_q, fwd_d, dout_q, dout_d;

   // Forwarding starts on the first rising edge after the store is full
   always_comb begin
      fwd_d = fwd_q;
      if (latch)
         fwd_d = 1'b0;
      else if ((state_q == ST_LOW) && s_q && (pix_idx_q == PW'(LED_CNT)))
         fwd_d = 1'b1;
      dout_d = fwd_d & s_q;
   end

   // Registered downstream output, three cycles behind din
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_q  <= 1'b0;
         dout_q <= 1'b0;
      end else begin
         fwd_q  <= fwd_d;
         dout_q <= dout_d;
      end
   end

   assign bus.dout = dout_q;
`else
   assign bus.dout = 1'b0;
`endif
endmodule
